// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker: assembles 3-byte PS/2 mouse packets and keeps a
// screen-clamped absolute cursor position plus left/right button state.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WAIT_B1 | idle, waiting for a header byte (bit 3 must be set)
// WAIT_B2 | header latched, waiting for dx low byte (idle timer runs)
// WAIT_B3 | dx latched, waiting for dy low byte (idle timer runs)
// UPDATE  | apply packet; a strobe here is treated as a new header byte
module mouse_cursor_tracker #(
  parameter int H_MAX   = 639,
  parameter int V_MAX   = 479,
  parameter int X_INIT  = 245,
  parameter int Y_INIT  = 245,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic [9:0] xm,
  output logic [9:0] ym,
  output logic       btn_l,
  output logic       btn_r,
  output logic       click_l_tick,
  output logic       packet_tick,
  output logic       sync_err_tick
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);
  localparam logic signed [11:0] H_LIM = 12'(H_MAX);
  localparam logic signed [11:0] V_LIM = 12'(V_MAX);

  typedef enum logic [1:0] {WAIT_B1, WAIT_B2, WAIT_B3, UPDATE} state_t;

  state_t          state, state_nx;
  logic [7:0]      b1, b2, b3;
  logic [CW-1:0]   idle_cnt, idle_nx;
  logic            ld_b1, ld_b2, ld_b3, upd, err;
  logic signed [11:0] dx, dy, nx, ny;

  // State, packet bytes and idle timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_B1;
      idle_cnt <= '0;
      b1       <= '0;
      b2       <= '0;
      b3       <= '0;
    end else begin
      state    <= state_nx;
      idle_cnt <= idle_nx;
      if (ld_b1) b1 <= rx_data;
      if (ld_b2) b2 <= rx_data;
      if (ld_b3) b3 <= rx_data;
    end
  end

  // Next-state logic: byte acceptance, header sync check and idle timeout
  always_comb begin
    state_nx = state;
    ld_b1    = 1'b0;
    ld_b2    = 1'b0;
    ld_b3    = 1'b0;
    upd      = 1'b0;
    err      = 1'b0;
    idle_nx  = '0;
    case (state)
      WAIT_B1, UPDATE: begin
        if (state == UPDATE) begin
          upd      = 1'b1;
          state_nx = WAIT_B1;
        end
        if (rx_done_tick) begin
          if (rx_data[3]) begin
            ld_b1    = 1'b1;
            state_nx = WAIT_B2;
          end else begin
            err = 1'b1;
          end
        end
      end
      WAIT_B2, WAIT_B3: begin
        if (rx_done_tick) begin
          if (state == WAIT_B2) begin
            ld_b2    = 1'b1;
            state_nx = WAIT_B3;
          end else begin
            ld_b3    = 1'b1;
            state_nx = UPDATE;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          err      = 1'b1;
          state_nx = WAIT_B1;
        end else begin
          idle_nx = idle_cnt + 1'b1;
        end
      end
      default: state_nx = WAIT_B1;
    endcase
  end

  // Sign-extended deltas (zeroed on overflow) and unclamped new position
  always_comb begin
    dx = b1[6] ? 12'sd0 : $signed({{3{b1[4]}}, b1[4], b2});
    dy = b1[7] ? 12'sd0 : $signed({{3{b1[5]}}, b1[5], b3});
    nx = $signed({2'b00, xm}) + dx;
    ny = $signed({2'b00, ym}) - dy;
  end

  // Registered cursor, buttons and event ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      xm            <= 10'(X_INIT);
      ym            <= 10'(Y_INIT);
      btn_l         <= 1'b0;
      btn_r         <= 1'b0;
      click_l_tick  <= 1'b0;
      packet_tick   <= 1'b0;
      sync_err_tick <= 1'b0;
    end else begin
      packet_tick   <= upd;
      click_l_tick  <= upd & b1[0] & ~btn_l;
      sync_err_tick <= err;
      if (upd) begin
        btn_l <= b1[0];
        btn_r <= b1[1];
        if (nx < 0)          xm <= '0;
        else if (nx > H_LIM) xm <= H_LIM[9:0];
        else                 xm <= nx[9:0];
        if (ny < 0)          ym <= '0;
        else if (ny > V_LIM) ym <= V_LIM[9:0];
        else                 ym <= ny[9:0];
      end
    end
  end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed testbench for mouse_cursor_tracker (short idle timeout).
module tb_mouse_cursor_tracker;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic [9:0] xm, ym;
  logic       btn_l, btn_r, click_l_tick, packet_tick, sync_err_tick;

  int n_checks = 0;
  int n_errs   = 0;
  int tick_cnt = 0;
  int err_cnt  = 0;
  int pkt_cnt  = 0;

  mouse_cursor_tracker #(
    .H_MAX(639), .V_MAX(479), .X_INIT(245), .Y_INIT(245), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .xm(xm), .ym(ym), .btn_l(btn_l), .btn_r(btn_r),
    .click_l_tick(click_l_tick), .packet_tick(packet_tick),
    .sync_err_tick(sync_err_tick)
  );

  always #5 clk = ~clk;

  // Event tallies used by the idle and timeout windows
  always @(posedge clk) begin
    if (packet_tick | click_l_tick | sync_err_tick) tick_cnt <= tick_cnt + 1;
    if (sync_err_tick) err_cnt <= err_cnt + 1;
    if (packet_tick) pkt_cnt <= pkt_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  // Sends a packet, then lands on the cycle after the output update
  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drive(a); drive(b); drive(c); idle();
    @(negedge clk);
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, "_x"}, int'(xm), ex);
    check({tag, "_y"}, int'(ym), ey);
    check({tag, "_pkt"}, int'(packet_tick), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_x", int'(xm), 245);
    check("rst_y", int'(ym), 245);
    check("rst_btn", int'({btn_l, btn_r}), 0);
    check("rst_ticks", int'({click_l_tick, packet_tick, sync_err_tick}), 0);
    tick_cnt = 0;
    repeat (10000) @(negedge clk);
    check("idle_ticks", tick_cnt, 0);
    check("idle_x", int'(xm), 245);

    send_pkt(8'h08, 8'h0A, 8'h05);
    check_pos("basic", 255, 240);
    @(negedge clk);
    check("basic_pkt_off", int'(packet_tick), 0);

    send_pkt(8'h18, 8'h00, 8'h00);
    check_pos("clamp_x0", 0, 240);
    send_pkt(8'h28, 8'h00, 8'h00);
    check_pos("clamp_ymax", 0, 479);
    send_pkt(8'h08, 8'hFF, 8'h00);
    check_pos("step255", 255, 479);
    send_pkt(8'h08, 8'hF5, 8'h00);
    check_pos("step500", 500, 479);
    send_pkt(8'h08, 8'hFF, 8'h00);
    check_pos("sat1", 639, 479);
    send_pkt(8'h08, 8'hFF, 8'h00);
    check_pos("sat2", 639, 479);
    send_pkt(8'h08, 8'hFF, 8'h00);
    check_pos("sat3", 639, 479);

    drive(8'h00); idle();
    check("bad_hdr_err", int'(sync_err_tick), 1);
    @(negedge clk);
    check("bad_hdr_err_off", int'(sync_err_tick), 0);
    check("bad_hdr_pkt", int'(packet_tick), 0);
    send_pkt(8'h18, 8'hF6, 8'h05);
    check_pos("recover", 629, 474);

    drive(8'h08); drive(8'h10); idle();
    err_cnt = 0;
    pkt_cnt = 0;
    repeat (TMO + 6) @(negedge clk);
    check("tmo_err", err_cnt, 1);
    check("tmo_pkt", pkt_cnt, 0);
    send_pkt(8'h08, 8'h0A, 8'h05);
    check_pos("after_tmo", 639, 469);

    send_pkt(8'h49, 8'h7F, 8'h01);
    check_pos("ovf_x", 639, 468);
    check("ovf_btn_l", int'(btn_l), 1);
    check("ovf_click", int'(click_l_tick), 1);
    @(negedge clk);
    check("ovf_click_off", int'(click_l_tick), 0);
    send_pkt(8'h49, 8'h7F, 8'h01);
    check_pos("ovf_rep", 639, 467);
    check("rep_click", int'(click_l_tick), 0);
    check("rep_btn_l", int'(btn_l), 1);
    send_pkt(8'h0A, 8'h00, 8'h00);
    check("btn_r_on", int'({btn_l, btn_r}), 1);
    send_pkt(8'h98, 8'h00, 8'hFF);
    check_pos("ovf_y", 383, 467);
    check("ovf_y_btn", int'({btn_l, btn_r}), 0);

    drive(8'h08); drive(8'h0A); idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_x", int'(xm), 245);
    check("midrst_y", int'(ym), 245);
    drive(8'h05); idle();
    check("midrst_err", int'(sync_err_tick), 1);
    check("midrst_pkt", int'(packet_tick), 0);
    @(negedge clk);
    check("midrst_x2", int'(xm), 245);

    drive(8'h08); drive(8'h0A); drive(8'h05);
    drive(8'h08); drive(8'h0A); drive(8'h05); idle();
    @(negedge clk);
    check_pos("b2b", 265, 235);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
